trace_axis_writer: RTL and testbench



---
 rtl/continuous_monitoring_system_pkg.sv | 23 ++
 rtl/axis_beat_fifo.sv | 45 ++++
 rtl/trace_axis_writer.sv | 66 ++++++
 tb/tb_trace_axis_writer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants for the continuous monitoring system trace path.
// Packet geometry and framing helper used by the AXI-Stream writer.
package continuous_monitoring_system_pkg;

  localparam int AXI_DATA_WIDTH    = 1024;
  localparam int XLEN              = 32;
  localparam int CLK_COUNTER_WIDTH = 64;

  localparam int PKT_TS_LSB      = 0;
  localparam int PKT_PC_LSB      = PKT_TS_LSB + CLK_COUNTER_WIDTH;
  localparam int PKT_INSN_LSB    = PKT_PC_LSB + XLEN;
  localparam int PKT_PAYLOAD_LSB = PKT_INSN_LSB + XLEN;

  function automatic logic frame_end(
    input logic [31:0] cnt,
    input logic [31:0] interval,
    input logic        force_last
  );
    return force_last |
      ((interval != 32'd0) && (cnt + 32'd1 == interval));
  endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a combinational head.
// Head reads zero while empty so an idle stream shows clean data.
module axis_beat_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trace_axis_writer.sv
// Trace packet strobes to AXI4-Stream master with tlast framing.
// Full-FIFO writes without a same-cycle pop are dropped and counted.
module trace_axis_writer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_pkt,
  input  logic [31:0]           tlast_interval,
  input  logic                  tlast,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                  M_AXIS_tlast,
  output logic [31:0]           overflow_count
);

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  beat_last;
  logic [31:0]           beat_cnt;
  logic [DATA_WIDTH:0]   head;

  assign pop       = !empty && M_AXIS_tready;
  assign push      = write_enable && (!full || pop);
  assign drop      = write_enable && full && !pop;
  assign beat_last = frame_end(beat_cnt, tlast_interval, tlast);

  axis_beat_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({beat_last, data_pkt}),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign M_AXIS_tvalid = !empty;
  assign M_AXIS_tlast  = head[DATA_WIDTH];
  assign M_AXIS_tdata  = head[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt       <= '0;
      overflow_count <= '0;
    end else begin
      if (push)
        beat_cnt <= beat_last ? 32'd0 : beat_cnt + 32'd1;
      if (drop && overflow_count != 32'hFFFF_FFFF)
        overflow_count <= overflow_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_trace_axis_writer.sv
// Directed self-checking bench for trace_axis_writer.
// Inputs change 1 time unit after each rising edge; outputs sampled then.
module tb_trace_axis_writer;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_enable;
  logic [DW-1:0] data_pkt;
  logic [31:0]   tlast_interval;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast_o;
  logic [31:0]   overflow_count;

  int checks   = 0;
  int failures = 0;

  trace_axis_writer #(
    .DATA_WIDTH (DW),
    .DEPTH      (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_enable   (write_enable),
    .data_pkt       (data_pkt),
    .tlast_interval (tlast_interval),
    .tlast          (tlast),
    .M_AXIS_tvalid  (tvalid),
    .M_AXIS_tready  (tready),
    .M_AXIS_tdata   (tdata),
    .M_AXIS_tlast   (tlast_o),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    write_enable = 1'b0;
    tlast = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic fl);
    write_enable = 1'b1;
    data_pkt = d;
    tlast = fl;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    tlast = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    write_enable = 1'b0;
    data_pkt = '0;
    tlast_interval = 32'd0;
    tlast = 1'b0;
    tready = 1'b0;
    #2;
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tlast", {63'd0, tlast_o}, 64'd0);
    chk("rst_ovf", {32'd0, overflow_count}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // single write
    tready = 1'b1;
    wr(64'hA5, 1'b0);
    step();
    idle();
    chk("t1_tvalid", {63'd0, tvalid}, 64'd1);
    chk("t1_tdata", tdata, 64'hA5);
    chk("t1_tlast", {63'd0, tlast_o}, 64'd0);
    step();
    chk("t1_tvalid_fall", {63'd0, tvalid}, 64'd0);

    // interval framing of 3
    do_reset();
    tlast_interval = 32'd3;
    tready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      wr(64'(k), 1'b0);
      step();
      chk($sformatf("t2_data_%0d", k), tdata, 64'(k));
      chk($sformatf("t2_last_%0d", k), {63'd0, tlast_o},
          (k == 3 || k == 6) ? 64'd1 : 64'd0);
    end
    idle();
    step();
    chk("t2_empty", {63'd0, tvalid}, 64'd0);

    // forced tlast restarts the frame
    do_reset();
    tlast_interval = 32'd100;
    for (int k = 1; k <= 4; k++) begin
      wr(64'h30 + 64'(k), k == 3);
      step();
      chk($sformatf("t3_data_%0d", k), tdata, 64'h30 + 64'(k));
      chk($sformatf("t3_last_%0d", k), {63'd0, tlast_o},
          (k == 3) ? 64'd1 : 64'd0);
    end
    tlast_interval = 32'd2;
    wr(64'h35, 1'b0);
    step();
    idle();
    chk("t3_data_5", tdata, 64'h35);
    chk("t3_last_5", {63'd0, tlast_o}, 64'd1);
    step();

    // overflow while stalled; the dropped 6th beat carries a forced tlast
    do_reset();
    tlast_interval = 32'd0;
    tready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wr(64'h10 + 64'(k), k == 6);
      step();
    end
    idle();
    chk("t4_ovf", {32'd0, overflow_count}, 64'd2);
    chk("t4_head", tdata, 64'h11);
    chk("t4_tvalid", {63'd0, tvalid}, 64'd1);
    step();
    chk("t4_hold", tdata, 64'h11);

    // full with simultaneous pop and push: no drop
    tready = 1'b1;
    wr(64'h17, 1'b0);
    step();
    idle();
    chk("t5_ovf", {32'd0, overflow_count}, 64'd2);
    chk("t5_head0", tdata, 64'h12);
    step();
    chk("t5_head1", tdata, 64'h13);
    step();
    chk("t5_head2", tdata, 64'h14);
    step();
    chk("t5_head3", tdata, 64'h17);
    chk("t5_last3", {63'd0, tlast_o}, 64'd0);
    step();
    chk("t5_empty", {63'd0, tvalid}, 64'd0);

    // reset mid-stream
    do_reset();
    tlast_interval = 32'd2;
    tready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wr(64'h40 + 64'(k), 1'b0);
      step();
    end
    idle();
    chk("t6_queued", {63'd0, tvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_tvalid", {63'd0, tvalid}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    tready = 1'b1;
    wr(64'h99, 1'b0);
    step();
    chk("t6_data_a", tdata, 64'h99);
    chk("t6_last_a", {63'd0, tlast_o}, 64'd0);
    wr(64'h9A, 1'b0);
    step();
    idle();
    chk("t6_data_b", tdata, 64'h9A);
    chk("t6_last_b", {63'd0, tlast_o}, 64'd1);
    step();
    chk("t6_empty", {63'd0, tvalid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
